// File: rtl/audio_pkg.sv
// Shared audio types: sample width, slot width, channel and run-state encodings.
package audio_pkg;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;

    typedef logic [DATA_W-1:0] sample_t;

    // lrck encoding: 0 selects the left channel, 1 the right channel.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    typedef enum logic {
        RUN_IDLE   = 1'b0,
        RUN_ACTIVE = 1'b1
    } run_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider and run gating. Produces bclk and a one-cycle tick on the
// clk cycle that ends with a bclk falling edge. Stops only at a frame boundary.
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic frame_end,
    output logic bclk,
    output logic tick_fall,
    output logic stop
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    run_e          state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          run_en, at_top;

    // An idle block with enable=1 starts counting in the same cycle it goes
    // active, so the first bclk rise lands exactly CLK_DIV cycles after start.
    assign run_en    = (state_q == RUN_ACTIVE) || enable;
    assign at_top    = (div_cnt_q == DIV_MAX);
    assign tick_fall = run_en && at_top && bclk_q;
    assign stop      = tick_fall && frame_end && !enable;
    assign bclk      = bclk_q;

    // Next-state: divider advance, bclk toggle, idle/active transitions.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        if (run_en) begin
            state_d = RUN_ACTIVE;
            if (at_top) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
            if (stop) begin
                state_d = RUN_IDLE;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN_IDLE;
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_tx_reader.sv
// Drains the playback FIFO into an I2S stream: one pop per channel slot,
// left-justified with the one-bit I2S delay, muted pairs on left underrun.
module i2s_tx_reader
    import audio_pkg::*;
#(
    parameter int DATA    = DATA_W,
    parameter int SLOT    = SLOT_W,
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [DATA-1:0] fifo_rdata,
    input  logic            fifo_empty,
    output logic            fifo_read,
    output logic            bclk,
    output logic            lrck,
    output logic            dout,
    output logic            underrun
);

    localparam int BW = $clog2(SLOT);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT - 1);

    chan_e           lrck_q, lrck_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SLOT-1:0] shifter_q, shifter_d, load_word;
    logic            mute_q, mute_d;
    logic            underrun_q, underrun_d;
    logic            tick_fall, stop, frame_end, slot_start, enter_left;

    assign frame_end = (bit_cnt_q == BIT_LAST) && (lrck_q == CH_RIGHT);

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .frame_end (frame_end),
        .bclk      (bclk),
        .tick_fall (tick_fall),
        .stop      (stop)
    );

    // A stopping frame boundary is not a slot start: lrck stays right, no pop.
    assign slot_start = tick_fall && (bit_cnt_q == BIT_LAST) && !stop;
    assign enter_left = (lrck_q == CH_RIGHT);
    // A muted left slot also mutes its right partner so L/R pairing survives.
    assign fifo_read  = reset && slot_start && !fifo_empty && (enter_left || !mute_q);
    // Slot word: leading 0 bit, sample MSB-first, zero padding to SLOT bits.
    assign load_word  = SLOT'(fifo_rdata) << (SLOT - 1 - DATA);

    assign lrck     = lrck_q;
    assign dout     = shifter_q[SLOT-1];
    assign underrun = underrun_q;

    // Slot sequencing, fetch decision and serial shift.
    always_comb begin
        lrck_d     = lrck_q;
        bit_cnt_d  = bit_cnt_q;
        shifter_d  = shifter_q;
        mute_d     = mute_q;
        underrun_d = 1'b0;
        if (stop) begin
            shifter_d = '0;
        end else if (slot_start) begin
            lrck_d    = enter_left ? CH_LEFT : CH_RIGHT;
            bit_cnt_d = '0;
            shifter_d = fifo_read ? load_word : '0;
            if (enter_left) begin
                mute_d     = fifo_empty;
                underrun_d = fifo_empty;
            end
        end else if (tick_fall) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shifter_d = {shifter_q[SLOT-2:0], 1'b0};
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lrck_q     <= CH_RIGHT;
            bit_cnt_q  <= BIT_LAST;
            shifter_q  <= '0;
            mute_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            lrck_q     <= lrck_d;
            bit_cnt_q  <= bit_cnt_d;
            shifter_q  <= shifter_d;
            mute_q     <= mute_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
